// File: rtl/agu_arbiter.sv
// ============================================================================
// Module   : agu_arbiter
// Purpose  : Round-robin scheduler sharing a single-cycle AGU between the
//            load pipe (requester 0) and store pipe (requester 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module agu_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,

  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_index,
  input  logic [WIDTH-1:0] i_req0_base,
  input  logic [1:0]       i_req0_shift,
  input  logic [TAG_W-1:0] i_req0_tag,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_addr,
  output logic [TAG_W-1:0] o_rsp0_tag,

  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_index,
  input  logic [WIDTH-1:0] i_req1_base,
  input  logic [1:0]       i_req1_shift,
  input  logic [TAG_W-1:0] i_req1_tag,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_addr,
  output logic [TAG_W-1:0] o_rsp1_tag,

  output logic             o_agu_start,
  output logic [WIDTH-1:0] o_agu_op1,
  output logic [WIDTH-1:0] o_agu_op2,
  output logic [1:0]       o_agu_shift,
  input  logic             i_agu_valid,
  input  logic [WIDTH-1:0] i_agu_result
);

  logic [1:0] req_valid_w;
  logic [1:0] rsp_ready_w;
  logic [1:0] elig_w;
  logic [1:0] grant_w;
  logic [1:0] load_w;

  logic             inflight_valid_q, inflight_valid_d;
  logic             inflight_owner_q, inflight_owner_d;
  logic [TAG_W-1:0] inflight_tag_q,   inflight_tag_d;
  logic             last_grant_q,     last_grant_d;

  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [1:0][WIDTH-1:0] rsp_addr_q,  rsp_addr_d;
  logic [1:0][TAG_W-1:0] rsp_tag_q,   rsp_tag_d;

  assign req_valid_w = {i_req1_valid, i_req0_valid};
  assign rsp_ready_w = {i_rsp1_ready, i_rsp0_ready};

  // A requester may not issue while its previous op is still in the AGU,
  // nor while its response slot holds a result that is not leaving this cycle.
  for (genvar k = 0; k < 2; k++) begin : g_req
    assign elig_w[k] = req_valid_w[k]
                     && !(inflight_valid_q && (inflight_owner_q == 1'(k)))
                     && (!rsp_valid_q[k] || rsp_ready_w[k]);
    assign load_w[k] = i_agu_valid && inflight_valid_q
                     && (inflight_owner_q == 1'(k));
  end

  always_comb begin
    grant_w = 2'b00;
    if (!i_rst) begin
      case (elig_w)
        2'b01:   grant_w = 2'b01;
        2'b10:   grant_w = 2'b10;
        2'b11:   grant_w = last_grant_q ? 2'b01 : 2'b10;
        default: grant_w = 2'b00;
      endcase
    end
  end

  always_comb begin
    o_agu_op1   = '0;
    o_agu_op2   = '0;
    o_agu_shift = '0;
    if (grant_w[0]) begin
      o_agu_op1   = i_req0_index;
      o_agu_op2   = i_req0_base;
      o_agu_shift = i_req0_shift;
    end else if (grant_w[1]) begin
      o_agu_op1   = i_req1_index;
      o_agu_op2   = i_req1_base;
      o_agu_shift = i_req1_shift;
    end
  end

  always_comb begin
    inflight_valid_d = |grant_w;
    inflight_owner_d = inflight_owner_q;
    inflight_tag_d   = inflight_tag_q;
    last_grant_d     = last_grant_q;
    if (grant_w[0]) begin
      inflight_owner_d = 1'b0;
      inflight_tag_d   = i_req0_tag;
      last_grant_d     = 1'b0;
    end else if (grant_w[1]) begin
      inflight_owner_d = 1'b1;
      inflight_tag_d   = i_req1_tag;
      last_grant_d     = 1'b1;
    end
  end

  // A reload wins over a same-cycle consume; addr/tag hold once consumed.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_tag_d   = rsp_tag_q;
    for (int k = 0; k < 2; k++) begin
      if (load_w[k]) begin
        rsp_valid_d[k] = 1'b1;
        rsp_addr_d[k]  = i_agu_result;
        rsp_tag_d[k]   = inflight_tag_q;
      end else if (rsp_valid_q[k] && rsp_ready_w[k]) begin
        rsp_valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight_valid_q <= 1'b0;
      inflight_owner_q <= 1'b0;
      inflight_tag_q   <= '0;
      last_grant_q     <= 1'b1;
      rsp_valid_q      <= '0;
      rsp_addr_q       <= '0;
      rsp_tag_q        <= '0;
    end else begin
      inflight_valid_q <= inflight_valid_d;
      inflight_owner_q <= inflight_owner_d;
      inflight_tag_q   <= inflight_tag_d;
      last_grant_q     <= last_grant_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_addr_q       <= rsp_addr_d;
      rsp_tag_q        <= rsp_tag_d;
    end
  end

  assign o_req0_ready = grant_w[0];
  assign o_req1_ready = grant_w[1];
  assign o_agu_start  = |grant_w;
  assign o_rsp0_valid = rsp_valid_q[0];
  assign o_rsp0_addr  = rsp_addr_q[0];
  assign o_rsp0_tag   = rsp_tag_q[0];
  assign o_rsp1_valid = rsp_valid_q[1];
  assign o_rsp1_addr  = rsp_addr_q[1];
  assign o_rsp1_tag   = rsp_tag_q[1];

`ifndef SYNTHESIS
  a_no_orphan_result: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_agu_valid && !inflight_valid_q));
`endif

endmodule

`default_nettype wire

// File: tb/tb_agu_arbiter.sv
// ============================================================================
// Module   : tb_agu_arbiter
// Purpose  : Directed and randomized bench for agu_arbiter with an AGU model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_agu_arbiter;
  localparam int W  = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          v0, v1, rr0, rr1;
  logic [W-1:0]  idx0, idx1, base0, base1;
  logic [1:0]    sh0, sh1;
  logic [TW-1:0] tg0, tg1;

  logic          ready0, ready1, rv0, rv1;
  logic [W-1:0]  ra0, ra1;
  logic [TW-1:0] rt0, rt1;
  logic          start;
  logic [W-1:0]  op1, op2;
  logic [1:0]    shift;
  logic          agu_valid = 1'b0;
  logic [W-1:0]  agu_result = '0;

  agu_arbiter #(.WIDTH(W), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(ready0), .i_req0_index(idx0),
    .i_req0_base(base0), .i_req0_shift(sh0), .i_req0_tag(tg0),
    .o_rsp0_valid(rv0), .i_rsp0_ready(rr0), .o_rsp0_addr(ra0), .o_rsp0_tag(rt0),
    .i_req1_valid(v1), .o_req1_ready(ready1), .i_req1_index(idx1),
    .i_req1_base(base1), .i_req1_shift(sh1), .i_req1_tag(tg1),
    .o_rsp1_valid(rv1), .i_rsp1_ready(rr1), .o_rsp1_addr(ra1), .o_rsp1_tag(rt1),
    .o_agu_start(start), .o_agu_op1(op1), .o_agu_op2(op2), .o_agu_shift(shift),
    .i_agu_valid(agu_valid), .i_agu_result(agu_result)
  );

  // Single-cycle AGU that never stalls.
  always @(posedge clk) begin
    agu_valid  <= start;
    agu_result <= (op1 << shift) + op2;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string name, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  // Reference state: the op issued last cycle and what each response slot holds.
  bit            m_last;
  bit            m_iss_v;
  bit            m_iss_own;
  logic [W-1:0]  m_iss_addr;
  logic [TW-1:0] m_iss_tag;
  bit            m_rsp_v [2];
  logic [W-1:0]  m_rsp_a [2];
  logic [TW-1:0] m_rsp_t [2];

  function automatic logic [W-1:0] agu_calc(input logic [W-1:0] idx,
      input logic [1:0] sh, input logic [W-1:0] base);
    longint unsigned full;
    full = (longint'(idx) * (longint'(1) << sh)) + longint'(base);
    return W'(full % (longint'(1) << W));
  endfunction

  task automatic model_reset();
    m_last  = 1'b1;
    m_iss_v = 1'b0;
    for (int k = 0; k < 2; k++) m_rsp_v[k] = 1'b0;
  endtask

  task automatic step();
    bit e0, e1, g0, g1;
    logic [W-1:0] eop1, eop2, nxt_addr;
    logic [1:0] esh;
    logic [TW-1:0] nxt_tag;
    bit rr [2];
    #1;
    rr[0] = rr0; rr[1] = rr1;
    e0 = v0 && !(m_iss_v && !m_iss_own) && (!m_rsp_v[0] || rr0);
    e1 = v1 && !(m_iss_v &&  m_iss_own) && (!m_rsp_v[1] || rr1);
    g0 = !rst && e0 && (!e1 || m_last);
    g1 = !rst && e1 && (!e0 || !m_last);
    eop1 = g0 ? idx0  : g1 ? idx1  : '0;
    eop2 = g0 ? base0 : g1 ? base1 : '0;
    esh  = g0 ? sh0   : g1 ? sh1   : '0;
    check_val("req0_ready", ready0, g0);
    check_val("req1_ready", ready1, g1);
    check_val("agu_start", start, g0 | g1);
    check_val("agu_op1", op1, eop1);
    check_val("agu_op2", op2, eop2);
    check_val("agu_shift", shift, esh);
    check_val("rsp0_valid", rv0, m_rsp_v[0]);
    check_val("rsp1_valid", rv1, m_rsp_v[1]);
    if (m_rsp_v[0]) begin
      check_val("rsp0_addr", ra0, m_rsp_a[0]);
      check_val("rsp0_tag", rt0, m_rsp_t[0]);
    end
    if (m_rsp_v[1]) begin
      check_val("rsp1_addr", ra1, m_rsp_a[1]);
      check_val("rsp1_tag", rt1, m_rsp_t[1]);
    end
    nxt_addr = g1 ? agu_calc(idx1, sh1, base1) : agu_calc(idx0, sh0, base0);
    nxt_tag  = g1 ? tg1 : tg0;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++)
        if (m_rsp_v[k] && rr[k]) m_rsp_v[k] = 1'b0;
      if (m_iss_v) begin
        m_rsp_v[m_iss_own] = 1'b1;
        m_rsp_a[m_iss_own] = m_iss_addr;
        m_rsp_t[m_iss_own] = m_iss_tag;
      end
      m_iss_v    = g0 | g1;
      m_iss_own  = g1;
      m_iss_addr = nxt_addr;
      m_iss_tag  = nxt_tag;
      if (g0 | g1) m_last = g1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
  endtask

  task automatic rand_ops();
    idx0 = $urandom; base0 = $urandom; sh0 = 2'($urandom); tg0 = TW'($urandom);
    idx1 = $urandom; base1 = $urandom; sh1 = 2'($urandom); tg1 = TW'($urandom);
  endtask

  initial begin
    idle();
    rand_ops();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    #2;
    check_val("rst_rsp0_addr", ra0, 0);
    check_val("rst_rsp0_tag", rt0, 0);
    check_val("rst_rsp1_addr", ra1, 0);
    check_val("rst_rsp1_tag", rt1, 0);
    v0 = 1'b1; v1 = 1'b1;
    step();

    // Single op on requester 0
    idle();
    v0 = 1'b1; idx0 = 32'h10; sh0 = 2'd2; base0 = 32'h1000; tg0 = 4'd3;
    #2 check_val("single_grant", ready0, 1);
    step();
    idle(); step();
    #2;
    check_val("single_valid", rv0, 1);
    check_val("single_addr", ra0, 32'h1040);
    check_val("single_tag", rt0, 3);
    check_val("single_rsp1_idle", rv1, 0);
    step();

    // Address wrap on requester 1
    idle();
    v1 = 1'b1; idx1 = 32'hFFFF_FFFF; sh1 = 2'd3; base1 = 32'h10; tg1 = 4'd9;
    step();
    idle(); step();
    #2 check_val("wrap_addr", ra1, 32'h8);
    step(); step();

    // Same requester back-to-back: every other cycle only
    for (int i = 0; i < 4; i++) begin
      idle(); v0 = 1'b1; rand_ops();
      #2 check_val("b2b_ready0", ready0, (i % 2) == 0);
      step();
    end
    idle(); step(); step();

    // Reset while an op is in the AGU, then contention
    idle(); v0 = 1'b1; rand_ops();
    step();
    idle(); rst = 1'b1; step();
    for (int i = 0; i < 4; i++) begin
      idle(); v0 = 1'b1; v1 = 1'b1; rand_ops();
      #2;
      if (i == 0) check_val("rst_drop_rsp0", rv0, 0);
      check_val("cont_ready0", ready0, (i % 2) == 0);
      check_val("cont_start", start, 1);
      step();
    end
    idle(); step(); step();

    // Backpressure on requester 1
    idle(); v1 = 1'b1; rand_ops(); step();
    idle(); step();
    for (int i = 0; i < 5; i++) begin
      idle(); v1 = 1'b1; rr1 = (i == 4); rand_ops();
      #2 check_val("bp_ready1", ready1, i == 4);
      step();
    end
    idle(); step(); step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      v0  = ($urandom_range(0, 9) < 7);
      v1  = ($urandom_range(0, 9) < 7);
      rr0 = ($urandom_range(0, 9) < 6);
      rr1 = ($urandom_range(0, 9) < 6);
      rand_ops();
      step();
    end
    idle(); step(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/agu_arbiter.md
Name: agu_arbiter

Overview:
Two-requester scheduler in front of the address generation unit (AGU). It shares the single-cycle-latency AGU between the load pipe (requester 0) and the store pipe (requester 1) using round-robin. Each granted operation is issued to the AGU, and the returned address is steered into a per-requester response register with valid/ready handshake. It sits between the LSU issue queues and the AGU.

Parameters:
WIDTH, 32, operand/address width; must match the AGU width
TAG_W, 4, width of the opaque requester tag carried alongside each operation

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_req0_valid  in  1  requester 0 has an operation
o_req0_ready  out  1  requester 0 operation accepted this cycle
i_req0_index  in  WIDTH  value to be shifted (AGU op1)
i_req0_base  in  WIDTH  value to be added (AGU op2)
i_req0_shift  in  2  left-shift amount 0..3
i_req0_tag  in  TAG_W  tag returned with the result
o_rsp0_valid  out  1  requester 0 result available
i_rsp0_ready  in  1  requester 0 consumes result
o_rsp0_addr  out  WIDTH  computed address
o_rsp0_tag  out  TAG_W  tag of the computed address
(i_req1_*, o_req1_ready, o_rsp1_*, i_rsp1_ready: identical set for requester 1)
o_agu_start  out  1  issue strobe to the AGU
o_agu_op1  out  WIDTH  AGU op1 (index)
o_agu_op2  out  WIDTH  AGU op2 (base)
o_agu_shift  out  2  AGU shift select
i_agu_valid  in  1  AGU result valid; one cycle after o_agu_start
i_agu_result  in  WIDTH  AGU result, (op1 << shift) + op2, mod 2^WIDTH

Behaviour:
- AGU contract: o_agu_start in cycle N gives i_agu_valid and i_agu_result in cycle N+1. The AGU never stalls.
- State: inflight_valid, inflight_owner, inflight_tag; rsp_k register (valid, addr, tag) per requester; last_grant pointer.
- Eligibility of requester k in cycle N, all of these must hold:
  - i_reqk_valid
  - NOT (inflight_valid && inflight_owner==k)
  - (!o_rspk_valid || i_rspk_ready)
- Grant (combinational):
  - Exactly one eligible: that requester wins.
  - Both eligible: the requester != last_grant wins.
  - o_reqk_ready = grant_k.
  - o_agu_start = grant0|grant1.
  - op1/op2/shift are muxed from the granted requester. They are zero when there is no grant.
- On a grant at the clock edge:
  - inflight_valid <= 1; inflight_owner <= k; inflight_tag <= i_reqk_tag.
  - last_grant <= k.
  - No grant: inflight_valid <= 0, last_grant holds.
- On i_agu_valid && inflight_valid at the edge: rsp_owner <= {valid=1, addr=i_agu_result, tag=inflight_tag}.
- rsp_k clears on (o_rspk_valid && i_rspk_ready) unless it is reloaded in the same cycle. A reload takes priority; eligibility guarantees no overwrite of an unconsumed result.
- i_agu_valid without inflight_valid is ignored. This is a simulation assertion error.
- Latency: request accepted in cycle N means o_rspk_valid in cycle N+2.
- Throughput:
  - The AGU can issue every cycle when the requesters alternate.
  - A single requester issues at most every 2 cycles.
- Arithmetic: no saturation; the address wraps modulo 2^WIDTH, as the AGU computes it. The arbiter does not modify operands.
- Reset (synchronous, i_rst=1 at an edge):
  - inflight_valid=0, rsp0/rsp1 valid=0, addr/tag=0, last_grant=1 (requester 0 wins the first contention).
  - All grants are forced to 0 while i_rst=1, so o_agu_start=0 and o_reqk_ready=0.
  - An AGU result arriving in the cycle after reset is discarded because inflight was cleared.
- Output reset values: o_req*_ready=0, o_rsp*_valid=0, o_rsp*_addr=0, o_rsp*_tag=0, o_agu_start=0, o_agu_op1/op2=0, o_agu_shift=0.

Test Plan:
- Single op: req0 index=0x10, shift=2, base=0x1000, tag=3 in cycle 0 -> o_req0_ready=1 and o_agu_start=1 in cycle 0; o_rsp0_valid=1 with addr=0x1040, tag=3 in cycle 2; rsp1 stays idle.
- Contention: both requesters valid continuously, rsp ready=1 -> grants go 0,1,0,1 in cycles 0..3 and o_agu_start=1 every cycle; each result lands on its own response port with the correct tag.
- Same-requester back-to-back: req0 only, valid for 4 cycles -> grants in cycles 0 and 2 only; o_req0_ready=0 in cycles 1 and 3.
- Backpressure: i_rsp1_ready=0 with rsp1 full, req1 valid -> req1 never granted and rsp1 addr/tag stable; i_rsp1_ready=1 in cycle K -> req1 granted in cycle K, new result valid in K+2.
- Wrap: index=0xFFFF_FFFF, shift=3, base=0x10 -> addr=0x0000_0008.
- Reset mid-op: req0 granted in cycle 0, i_rst=1 in cycle 1 (AGU still returns valid) -> o_rsp0_valid stays 0 in cycle 2; after reset, contention grants requester 0 first.
